// File: rtl/misc_v_pkg.sv
// Shared definitions for the MISC-V pipeline: word/register widths and MEM stage FSM states.
package misc_v_pkg;
  localparam int WORD_W     = 16;
  localparam int REG_ADDR_W = 3;

  typedef enum logic {
    MS_RUN  = 1'b0,
    MS_WAIT = 1'b1
  } mem_state_t;
endpackage

// File: rtl/misc_data_ram.sv
// Word-wide data RAM: one asynchronous read port, one synchronous write port, no reset.
module misc_data_ram
  import misc_v_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];
endmodule

// File: rtl/memory_stage.sv
// MEM stage of the MISC-V pipeline: EX/MEM register, data RAM, wait-state FSM.
// Optional macro MEM_MISALIGN_CHECK_EN: odd-address memory ops fault instead of accessing RAM.
module memory_stage
  import misc_v_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ex_valid,
  input  logic                  ex_mem_read,
  input  logic                  ex_mem_write,
  input  logic                  ex_reg_write,
  input  logic                  ex_reg_store,
  input  logic [WORD_W-1:0]     ex_alu_result,
  input  logic [WORD_W-1:0]     ex_store_data,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  mem_stall,
  output logic                  RegWrite,
  output logic                  RegStore,
  output logic [WORD_W-1:0]     ALUResult,
  output logic [WORD_W-1:0]     StoreMem,
  output logic [REG_ADDR_W-1:0] rdWB,
  output logic                  misalign_fault
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(MEM_LATENCY - 1);
  localparam logic             MULTI_CYC = (MEM_LATENCY > 1);

  logic                  valid_p1, mem_read_p1, mem_write_p1, reg_write_p1, reg_store_p1;
  logic [WORD_W-1:0]     alu_result_p1, store_data_p1;
  logic [REG_ADDR_W-1:0] rd_p1;

  mem_state_t     state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;

  logic              ex_mem_op, ex_misalign, mem_op, fault, ram_we, load_out;
  logic [WORD_W-1:0] ram_rdata;

  assign mem_stall = (state == MS_WAIT);
  assign ex_mem_op = ex_valid & (ex_mem_read | ex_mem_write);
  assign mem_op    = valid_p1 & (mem_read_p1 | mem_write_p1);

`ifdef MEM_MISALIGN_CHECK_EN
  assign ex_misalign = ex_alu_result[0];
  assign fault       = mem_op & alu_result_p1[0];
`else
  assign ex_misalign = 1'b0;
  assign fault       = 1'b0;
`endif

  // EX -> MEM boundary: capture only when no access is in flight
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_p1      <= 1'b0;
      mem_read_p1   <= 1'b0;
      mem_write_p1  <= 1'b0;
      reg_write_p1  <= 1'b0;
      reg_store_p1  <= 1'b0;
      alu_result_p1 <= '0;
      store_data_p1 <= '0;
      rd_p1         <= '0;
    end else if (!mem_stall) begin
      valid_p1      <= ex_valid;
      mem_read_p1   <= ex_mem_read;
      mem_write_p1  <= ex_mem_write;
      reg_write_p1  <= ex_reg_write;
      reg_store_p1  <= ex_reg_store;
      alu_result_p1 <= ex_alu_result;
      store_data_p1 <= ex_store_data;
      rd_p1         <= ex_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= MS_RUN;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // The FSM looks at the incoming op because the decision is made on the capturing edge
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      MS_RUN: begin
        if (MULTI_CYC && ex_mem_op && !ex_misalign) begin
          state_next = MS_WAIT;
          cnt_next   = WAIT_INIT;
        end
      end
      MS_WAIT: begin
        cnt_next = cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          state_next = MS_RUN;
        end
      end
      default: state_next = MS_RUN;
    endcase
  end

  // Gating the write with reset lets a reset on the completion edge abort the store
  assign ram_we   = mem_op & mem_write_p1 & ~mem_stall & ~fault & reset;
  assign load_out = valid_p1 & mem_read_p1 & ~mem_stall & ~fault;

  misc_data_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (alu_result_p1[AW:1]),
    .wdata (store_data_p1),
    .rdata (ram_rdata)
  );

  assign RegWrite       = valid_p1 & reg_write_p1 & ~mem_stall & ~fault;
  assign RegStore       = reg_store_p1;
  assign ALUResult      = alu_result_p1;
  assign rdWB           = rd_p1;
  assign StoreMem       = load_out ? ram_rdata : '0;
  assign misalign_fault = fault;
endmodule
